// File: rtl/tlul_source_remap_pkg.sv
// Shared TL-UL types and constants for the host-side source remapper.
package tlul_source_remap_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;

  // Largest pool that still leaves the source MSB free for the socket's port index.
  localparam int RemapMaxSlots = 2 ** (TL_AIW - 1);

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  // Slot index width, never narrower than one bit.
  function automatic int remap_slot_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlul_source_remap_alloc.sv
// Slot pool: busy vector, lowest-free picker, full flag and occupancy counter.
module tlul_source_remap_alloc
  import tlul_source_remap_pkg::*;
#(
  parameter int NumSlots = 4,
  parameter int SlotW    = 2,
  parameter int CntW     = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                alloc_i,
  input  logic                free_i,
  input  logic [SlotW-1:0]    free_idx_i,
  output logic [SlotW-1:0]    alloc_idx_o,
  output logic                full_o,
  output logic [CntW-1:0]     cnt_o,
  output logic [NumSlots-1:0] busy_o
);

  logic [NumSlots-1:0] busy_q, busy_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                alloc_ok;

  assign full_o   = &busy_q;
  assign alloc_ok = alloc_i & ~full_o;

  // Lowest-index free slot; scanning downward lets the lowest match win.
  always_comb begin
    alloc_idx_o = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx_o = SlotW'(i);
    end
  end

  // Next busy vector and count; the allocated slot is free and the released one busy, so they never collide.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NumSlots; i++) begin
      if (alloc_ok && alloc_idx_o == SlotW'(i)) busy_d[i] = 1'b1;
      if (free_i && free_idx_i == SlotW'(i))    busy_d[i] = 1'b0;
    end
    cnt_d = cnt_q + CntW'(alloc_ok) - CntW'(free_i);
  end

  // Pool state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = busy_q;

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CntW'(NumSlots));
  a_no_alloc_full: assert property (@(posedge clk_i) disable iff (rst_i) !(alloc_i && full_o));
  a_cnt_popcount: assert property (@(posedge clk_i) disable iff (rst_i) int'(cnt_q) == $countones(busy_q));

endmodule

// File: rtl/tlul_source_remap.sv
// Compresses host a_source into a small slot pool and restores it on the D channel.
module tlul_source_remap
  import tlul_source_remap_pkg::*;
#(
  parameter int NumSlots   = 4,
  parameter bit ErrOnStray = 1'b1,
  localparam int SlotW     = remap_slot_w(NumSlots),
  localparam int CntW      = $clog2(NumSlots + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  tl_h2d_t         tl_h_i,
  output tl_d2h_t         tl_h_o,
  output tl_h2d_t         tl_d_o,
  input  tl_d2h_t         tl_d_i,
  output logic [CntW-1:0] outstanding_o,
  output logic            stray_rsp_o
);

  typedef logic [SlotW-1:0] tl_slot_t;

  tl_slot_t            free_idx, d_idx;
  logic                full, a_fire, d_fire, in_range, slot_busy, release_ok;
  logic [NumSlots-1:0] busy;
  logic [TL_AIW-1:0]   rd_src;
  logic [TL_AIW-1:0]   src_tbl_q [NumSlots];
  logic                stray_q;

  assign a_fire     = tl_h_i.a_valid & ~full & tl_d_i.a_ready;
  assign d_fire     = tl_d_i.d_valid & tl_h_i.d_ready;
  assign d_idx      = tl_d_i.d_source[SlotW-1:0];
  assign in_range   = (tl_d_i.d_source[TL_AIW-1:SlotW] == '0)
                    && ({1'b0, d_idx} < (SlotW + 1)'(NumSlots));
  assign release_ok = d_fire & slot_busy;

  tlul_source_remap_alloc #(
    .NumSlots (NumSlots),
    .SlotW    (SlotW),
    .CntW     (CntW)
  ) u_alloc (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alloc_i     (a_fire),
    .free_i      (release_ok),
    .free_idx_i  (d_idx),
    .alloc_idx_o (free_idx),
    .full_o      (full),
    .cnt_o       (outstanding_o),
    .busy_o      (busy)
  );

  // Response slot lookup; out-of-range indices read as an unallocated slot.
  always_comb begin
    rd_src    = '0;
    slot_busy = 1'b0;
    for (int i = 0; i < NumSlots; i++) begin
      if (in_range && d_idx == SlotW'(i)) begin
        rd_src    = src_tbl_q[i];
        slot_busy = busy[i];
      end
    end
  end

  // A channel toward the socket: gated valid, compressed source.
  always_comb begin
    tl_d_o          = tl_h_i;
    tl_d_o.a_valid  = tl_h_i.a_valid & ~full;
    tl_d_o.a_source = TL_AIW'(free_idx);
  end

  // D channel toward the host: restored source, stray responses flagged.
  always_comb begin
    tl_h_o          = tl_d_i;
    tl_h_o.a_ready  = tl_d_i.a_ready & ~full;
    tl_h_o.d_source = slot_busy ? rd_src : '0;
    tl_h_o.d_error  = tl_d_i.d_error | (ErrOnStray & ~slot_busy);
  end

  // Capture the host source into the slot being allocated.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSlots; i++) src_tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (a_fire && free_idx == SlotW'(i)) src_tbl_q[i] <= tl_h_i.a_source;
      end
    end
  end

  // Sticky record of any accepted response for an unallocated slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      stray_q <= 1'b0;
    else if (d_fire && !slot_busy)  stray_q <= 1'b1;
  end

  assign stray_rsp_o = stray_q;

endmodule

// File: tb/tb_tlul_source_remap.sv
// Directed plan scenarios plus random traffic, checked against a slot-pool model.
module tb_tlul_source_remap;
  import tlul_source_remap_pkg::*;

  localparam int N = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  tl_h2d_t    tl_h_i;
  tl_d2h_t    tl_h_o;
  tl_h2d_t    tl_d_o;
  tl_d2h_t    tl_d_i;
  logic [2:0] outstanding_o;
  logic       stray_rsp_o;

  int n_tests = 0;
  int n_fail  = 0;

  bit         m_busy [N];
  logic [7:0] m_src  [N];
  bit         m_stray;

  always #5 clk_i = ~clk_i;

  tlul_source_remap #(
    .NumSlots   (N),
    .ErrOnStray (1'b1)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .tl_h_i        (tl_h_i),
    .tl_h_o        (tl_h_o),
    .tl_d_o        (tl_d_o),
    .tl_d_i        (tl_d_i),
    .outstanding_o (outstanding_o),
    .stray_rsp_o   (stray_rsp_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic int m_lowest_free();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    tl_h_i = '0;
    tl_d_i = '0;
    rst_i  = 1'b1;
    #1;
    check("rst_outstanding", outstanding_o, 0);
    check("rst_stray", stray_rsp_o, 0);
    check("rst_a_valid", tl_d_o.a_valid, 0);
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0;
      m_src[i]  = '0;
    end
    m_stray = 1'b0;
    #2;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  // One clock of traffic: drive, compare against the model, then advance the model.
  task automatic cyc(input bit av, input logic [7:0] asrc, input bit ards,
                     input bit dv, input logic [7:0] dsrc, input bit dr, input bit derr);
    logic [31:0] addr, data;
    int          fi, slot;
    bit          full, stray;
    addr = $urandom;
    data = $urandom;
    tl_h_i           = '0;
    tl_h_i.a_valid   = av;
    tl_h_i.a_source  = asrc;
    tl_h_i.a_address = addr;
    tl_h_i.d_ready   = dr;
    tl_d_i           = '0;
    tl_d_i.a_ready   = ards;
    tl_d_i.d_valid   = dv;
    tl_d_i.d_source  = dsrc;
    tl_d_i.d_data    = data;
    tl_d_i.d_error   = derr;
    #1;
    fi    = m_lowest_free();
    full  = (fi < 0);
    slot  = (int'(dsrc) < N) ? int'(dsrc) : -1;
    stray = (slot < 0) || !m_busy[slot];
    check("a_valid", tl_d_o.a_valid, av && !full);
    check("a_ready", tl_h_o.a_ready, ards && !full);
    if (!full) check("a_source", tl_d_o.a_source, fi);
    check("a_address", tl_d_o.a_address, addr);
    check("d_ready", tl_d_o.d_ready, dr);
    check("d_valid", tl_h_o.d_valid, dv);
    check("d_source", tl_h_o.d_source, stray ? 8'h00 : m_src[slot]);
    check("d_error", tl_h_o.d_error, derr || stray);
    check("d_data", tl_h_o.d_data, data);
    check("outstanding", outstanding_o, m_count());
    check("stray_flag", stray_rsp_o, m_stray);
    @(posedge clk_i);
    if (av && ards && !full) begin
      m_busy[fi] = 1'b1;
      m_src[fi]  = asrc;
    end
    if (dv && dr) begin
      if (stray) m_stray = 1'b1;
      else       m_busy[slot] = 1'b0;
    end
    @(negedge clk_i);
  endtask

  task automatic idle();
    cyc(0, 8'h00, 1, 0, 8'h00, 1, 0);
  endtask

  initial begin
    logic [7:0] ds;
    int         pick;
    rst_i  = 1'b0;
    tl_h_i = '0;
    tl_d_i = '0;
    @(negedge clk_i);
    do_reset();

    // Single read round trip
    cyc(1, 8'h2A, 1, 0, 8'h00, 1, 0);
    check("t1_cnt_after_req", outstanding_o, 1);
    cyc(0, 8'h00, 1, 1, 8'h00, 1, 0);
    check("t1_cnt_after_rsp", outstanding_o, 0);

    // Four writes, fifth stalls, out-of-order responses
    cyc(1, 8'd5, 1, 0, 8'h00, 1, 0);
    cyc(1, 8'd9, 1, 0, 8'h00, 1, 0);
    cyc(1, 8'd3, 1, 0, 8'h00, 1, 0);
    cyc(1, 8'd7, 1, 0, 8'h00, 1, 0);
    check("t2_full_cnt", outstanding_o, 4);
    cyc(1, 8'h11, 1, 0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 1, 8'd2, 1, 0);
    cyc(0, 8'h00, 1, 1, 8'd0, 1, 0);
    cyc(0, 8'h00, 1, 1, 8'd3, 1, 0);
    cyc(0, 8'h00, 1, 1, 8'd1, 1, 0);
    check("t2_drained", outstanding_o, 0);

    // Full with simultaneous release: request waits one cycle, then takes slot 1
    cyc(1, 8'h31, 1, 0, 8'h00, 1, 0);
    cyc(1, 8'h32, 1, 0, 8'h00, 1, 0);
    cyc(1, 8'h33, 1, 0, 8'h00, 1, 0);
    cyc(1, 8'h34, 1, 0, 8'h00, 1, 0);
    cyc(1, 8'h44, 1, 1, 8'd1, 1, 0);
    cyc(1, 8'h44, 1, 0, 8'h00, 1, 0);
    check("t3_cnt", outstanding_o, 4);
    for (int i = 0; i < N; i++) cyc(0, 8'h00, 1, 1, 8'(i), 1, 0);

    // Release of slot 0 concurrent with allocation picks slot 1
    cyc(1, 8'h10, 1, 0, 8'h00, 1, 0);
    cyc(1, 8'h20, 1, 1, 8'd0, 1, 0);
    check("t4_cnt", outstanding_o, 1);
    cyc(0, 8'h00, 1, 1, 8'd1, 1, 0);

    // Stray response for a free slot
    cyc(0, 8'h00, 1, 1, 8'd2, 1, 0);
    check("t5_stray_set", stray_rsp_o, 1);
    idle();
    check("t5_stray_sticky", stray_rsp_o, 1);

    // Reset with three outstanding, late response becomes stray
    cyc(1, 8'h0A, 1, 0, 8'h00, 1, 0);
    cyc(1, 8'h0B, 1, 0, 8'h00, 1, 0);
    cyc(1, 8'h0C, 1, 0, 8'h00, 1, 0);
    check("t6_cnt_before_rst", outstanding_o, 3);
    do_reset();
    cyc(0, 8'h00, 1, 1, 8'd1, 1, 0);
    check("t6_late_stray", stray_rsp_o, 1);
    cyc(1, 8'h55, 1, 0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 1, 8'd0, 1, 0);

    // Random traffic, mostly legal responses with occasional strays
    for (int k = 0; k < 600; k++) begin
      if (m_count() > 0 && $urandom_range(0, 4) != 0) begin
        pick = $urandom_range(0, N - 1);
        while (!m_busy[pick]) pick = (pick + 1) % N;
        ds = 8'(pick);
      end else begin
        ds = 8'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, N - 1));
      end
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), ds, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
      if (k == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlul_source_remap.md
Name: tlul_source_remap

Overview:
- Per-host TL-UL stage placed directly upstream of each host port of the M:1 socket.
- Compresses arbitrary host a_source values into a small pool of slot IDs, so the MSB of the outgoing source is always 0, as the socket requires for its port-index insertion.
- Bounds the number of outstanding transactions per host.
- Restores the original source on the D channel.

Parameters:
- NumSlots, 4, maximum outstanding requests; legal range 1..2^(TL_AIW-1).
- SlotW, $clog2(NumSlots) (minimum 1), derived width of the slot index.
- ErrOnStray, 1'b1, when 1, a response carrying an unallocated slot is forwarded with d_error=1; when 0, it is forwarded unchanged apart from d_source.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- tl_h_i  in  tl_h2d_t  host request.
- tl_h_o  out  tl_d2h_t  host response.
- tl_d_o  out  tl_h2d_t  request toward the socket host port.
- tl_d_i  in  tl_d2h_t  response from the socket host port.
- outstanding_o  out  $clog2(NumSlots+1)  number of currently allocated slots.
- stray_rsp_o  out  1  sticky flag: a response was seen for a free slot.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is asynchronous and active-high.
- State:
  - busy[NumSlots] (slot allocated).
  - src_tbl[NumSlots] of TL_AIW bits (original host source).
  - stray flag.
- Reset values: busy all 0, src_tbl all 0, outstanding_o=0, stray_rsp_o=0. Resulting outputs: tl_d_o.a_valid=0 (unless the host drives a_valid, gated as below), tl_h_o.d_valid follows tl_d_i.d_valid.
- full = &busy. free_idx = lowest-index slot with busy=0.
- A channel is combinational, zero latency:
  - tl_d_o.a_valid = tl_h_i.a_valid & ~full.
  - tl_h_o.a_ready = tl_d_i.a_ready & ~full.
  - tl_d_o.a_source = zero-extended free_idx; all bits above SlotW are 0.
  - All other A fields and d_ready pass through unchanged.
- Allocation occurs on a_fire = tl_d_o.a_valid & tl_d_i.a_ready. At the next clock edge: busy[free_idx]<=1, src_tbl[free_idx]<=tl_h_i.a_source.
- D channel is combinational:
  - d_valid and all D fields pass through, except d_source = src_tbl[tl_d_i.d_source[SlotW-1:0]].
  - d_source index bits at or above SlotW, or an index >= NumSlots, count as stray.
- Release occurs on d_fire = tl_d_i.d_valid & tl_h_i.d_ready with the slot busy: at the next clock edge, busy[slot]<=0.
- Stray response (slot not busy or out of range):
  - The response is still forwarded; d_source is driven to 0.
  - d_error is forced to 1 if ErrOnStray.
  - stray_rsp_o sets on d_fire and stays set until reset.
  - busy is unchanged.
- Simultaneous a_fire and d_fire in one cycle:
  - Both take effect.
  - free_idx is computed from busy before the edge, so the slot being released is not reused in the same cycle.
  - outstanding_o is unchanged net.
- Full with a simultaneous release: a_ready stays 0 this cycle and rises in the following cycle.
- The counter never wraps. Assertions required:
  - outstanding_o <= NumSlots.
  - No a_fire while full.
  - outstanding_o == popcount(busy).
- Reset asserted mid-transaction: all slots are freed immediately (asynchronous). Responses arriving later for old slots are handled as stray.
- Mapping is not ordered. Any response order from downstream is legal.

Decomposition:
- tlul_pkg additions:
  - typedef tl_slot_t (parametric width via localparam in the module).
  - Constant RemapMaxSlots = 2**(top_pkg::TL_AIW-1).
- One sub-module, tlul_source_remap_alloc:
  - Contains the busy vector, lowest-free priority encoder, full flag and outstanding counter.
  - Inputs: alloc_i, free_i, free_idx_i.
  - Outputs: alloc_idx_o, full_o, cnt_o.
- src_tbl remains in the top module.

Test Plan:
- Single read, host a_source=0x2A, downstream ready → tl_d_o.a_source=0. Response with d_source=0 → tl_h_o.d_source=0x2A; outstanding 0→1→0.
- Four back-to-back writes with sources 5,9,3,7 (NumSlots=4) → slots 0,1,2,3 used; fifth request sees a_ready=0. Responses in order 2,0,3,1 → host sees 3,5,7,9.
- Full, then response for slot 1 with a new request in the same cycle → request stalls that cycle, is accepted the next cycle with slot 1; outstanding stays 4.
- Release of slot 0 concurrent with allocation while slots 1-3 are free → new request gets slot 1; outstanding remains 1.
- Response with d_source=2 while slot 2 is free → forwarded with d_error=1 and d_source=0; stray_rsp_o=1 and persists; outstanding unchanged.
- rst_i pulsed with 3 outstanding → outstanding_o=0 immediately. A later response for slot 1 raises stray_rsp_o. The next request gets slot 0.
